program_loader: RTL and testbench
=================================

# program_loader

Byte-stream boot loader that sits directly upstream of `program_memory`. It accepts framed bytes from the UART receiver over a valid/ready stream. It then clears program memory, writes the payload byte by byte through the memory's write port, and verifies a checksum. While loading it holds the CPU in reset and reports done or error.

## Interface
Parameters:
- `MEM_BYTES`, 1024: program memory size in bytes; the maximum accepted payload length.
- `START_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle cycles between bytes inside a frame.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `rx_data`  in  8: received byte.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: loader accepts a byte this cycle.
- `write_enable`  out  1: program memory byte write strobe.
- `write_data`  out  8: byte to write.
- `write_address`  out  32: byte address, 0..MEM_BYTES-1.
- `clear_mem`  out  1: one-cycle pulse that zeroes program memory.
- `cpu_hold`  out  1: holds the CPU and PC in reset.
- `load_done`  out  1: last frame loaded and verified.
- `load_error`  out  1: last frame failed.

## Operation
- Frame format: `START_BYTE`, then `LEN_LO`, then `LEN_HI` (16-bit payload length N, little-endian), then N payload bytes, then one checksum byte.
- Checksum: 8-bit sum mod 256 of the payload bytes.
- Handshake: a byte is accepted when `rx_valid && rx_ready`.
- `rx_ready` is 1 in every state except `CLEAR`.
- States, held in `loader_pkg::state_t`:
  - `IDLE`: bytes other than `START_BYTE` are dropped. `START_BYTE` moves to `CLEAR`, sets `cpu_hold`=1 and clears `load_done` and `load_error`.
  - `CLEAR`: lasts exactly one cycle with `clear_mem`=1, then moves to `LEN_LO`.
  - `LEN_LO`: the accepted byte sets length[7:0], then moves to `LEN_HI`.
  - `LEN_HI`: the accepted byte sets length[15:8].
    - N > `MEM_BYTES` goes to `ERROR`.
    - N = 0 goes to `CHECK`.
    - Otherwise goes to `DATA` with index=0 and sum=0.
  - `DATA`: each accepted byte issues one write at `write_address`=index, adds the byte to sum, and increments index. After byte N-1 it moves to `CHECK`.
  - `CHECK`: the accepted byte is compared with sum.
    - Equal goes to `DONE`.
    - Unequal goes to `ERROR`.
  - `DONE`: `load_done`=1, `cpu_hold`=0. Behaves as `IDLE`, so a new `START_BYTE` begins a new frame.
  - `ERROR`: `load_error`=1, `cpu_hold` stays 1 because memory is partial. Behaves as `IDLE` for restart.
- Timeout: in `LEN_LO`, `LEN_HI`, `DATA` or `CHECK`, `TIMEOUT_CYCLES` consecutive cycles without an accepted byte moves to `ERROR`. The counter clears on every accepted byte.
- A `START_BYTE` value inside a frame is treated as ordinary data, not as a resync.
- Width rules:
  - index is 16 bits, zero-extended onto `write_address`.
  - sum is 8 bits and wraps.
  - the length compare is unsigned.

## Timing
- Reset values: state `IDLE`; `rx_ready`=1; `write_enable`=0; `write_data`=0; `write_address`=0; `clear_mem`=0; `cpu_hold`=0; `load_done`=0; `load_error`=0.
- All outputs are registered.
- Start byte accepted at edge k: `clear_mem`=1 and `rx_ready`=0 during cycle k+1; `cpu_hold`=1 from k+1.
- Payload byte accepted at edge k: `write_enable`=1 for exactly cycle k+1, with `write_data` and `write_address` valid in that same cycle.
- Back-to-back bytes: one write per cycle, sustained. Each write precedes the next.
- The first write occurs no earlier than 3 cycles after `clear_mem`, so there is no clear/write collision in memory.
- Checksum byte accepted at edge k: `load_done` or `load_error` goes to 1 at k+1, and `cpu_hold` falls at k+1 on success.
- Timeout: the cycle-`TIMEOUT_CYCLES` boundary registers `ERROR` on the following edge.
- Asynchronous `rst` mid-frame: immediate return to the reset values. Memory already written is left as-is.

## Structure
- `loader_pkg` contains:
  - `state_t` enum;
  - `START_BYTE_DEFAULT`;
  - `LEN_W`=16 localparam.
- Sub-module `loader_timeout`: a resettable cycle counter with `clear` and `enable` inputs and an `expired` output, parameterised by `TIMEOUT_CYCLES`.
- The FSM, index counter and checksum accumulator live in `program_loader`.

## Test plan
- **Nominal frame:** stream A5 04 00 13 00 00 00 13 back-to-back.
  - `clear_mem` pulses once.
  - Writes land at addresses 0..3 with data 13,00,00,00.
  - `load_done`=1 and `cpu_hold`=0 one cycle after the checksum byte.
- **Bad checksum:** stream A5 02 00 01 02 04.
  - Two writes occur.
  - `load_error`=1, `cpu_hold` stays 1.
  - A following valid frame sets `load_done`=1 and clears `load_error`.
- **Oversize length:** stream A5 01 04 (N=1025).
  - `ERROR` is entered immediately after `LEN_HI`.
  - No `write_enable` is asserted.
- **Zero length with idle gaps:**
  - Stream A5 00 00 00 with 5 idle cycles between bytes: `load_done`=1 and no writes.
  - Stream A5 00 00 00 with a gap of `TIMEOUT_CYCLES` (reduced to 16 on the bench) after `LEN_LO`: `load_error`=1.
- **Noise, in-frame marker and reset:**
  - Bytes 00 FF before A5 are ignored.
  - A payload byte equal to A5 is written as data.
  - Asserting `rst` during `DATA` forces all outputs to their reset values within the same cycle.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;

    localparam int unsigned LEN_W = 16;
    localparam logic [7:0] START_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // States in which the inter-byte idle timer runs.
    function automatic logic in_frame(state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter; expired_o flags the last allowed idle cycle so the
// caller can register the timeout on the following edge.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses START/LEN/payload/checksum frames from the UART stream,
// clears and fills program memory, and holds the CPU until a frame verifies.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES      = 1024,
    parameter logic [7:0]  START_BYTE     = START_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        write_enable,
    output logic [7:0]  write_data,
    output logic [31:0] write_address,
    output logic        clear_mem,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output state_t      state_o
);

    // Stream handshake: a byte transfers on a rising edge where rx_valid and
    // rx_ready are both high; rx_ready is registered and low only in CLEAR.

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [7:0]       sum_q, sum_d;
    logic             rx_ready_q, rx_ready_d;
    logic             we_q, we_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [LEN_W-1:0] waddr_q, waddr_d;
    logic             clear_q, clear_d;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             expired;
    logic [LEN_W-1:0] len_in;

    assign accept = rx_valid && rx_ready_q;
    assign len_in = {rx_data, len_q[7:0]};

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (accept || !in_frame(state_q)),
        .enable_i (in_frame(state_q)),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        clear_d = 1'b0;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (accept && (rx_data == START_BYTE)) begin
                    state_d = CLEAR;
                    clear_d = 1'b1;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            CLEAR: state_d = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d = len_in;
                    idx_d = '0;
                    sum_d = '0;
                    if (32'(len_in) > MEM_BYTES) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else if (len_in == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    wdata_d = rx_data;
                    waddr_d = idx_q;
                    sum_d   = sum_q + rx_data;
                    idx_d   = idx_q + LEN_W'(1);
                    if (idx_q == (len_q - LEN_W'(1))) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (rx_data == sum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte arriving on the expiry cycle still counts.
        if (in_frame(state_q) && !accept && expired) begin
            state_d = ERROR;
            err_d   = 1'b1;
        end

        rx_ready_d = (state_d != CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            rx_ready_q <= 1'b1;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            clear_q    <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            clear_q    <= clear_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready      = rx_ready_q;
    assign write_enable  = we_q;
    assign write_data    = wdata_q;
    assign write_address = {{(32 - LEN_W){1'b0}}, waddr_q};
    assign clear_mem     = clear_q;
    assign cpu_hold      = hold_q;
    assign load_done     = done_q;
    assign load_error    = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level reference model compared every cycle,
// plus directed frames with literal write lists and status expectations.
module tb_program_loader;
    import loader_pkg::*;

    localparam int unsigned MEM = 1024;
    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        write_enable;
    logic [7:0]  write_data;
    logic [31:0] write_address;
    logic        clear_mem;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    state_t      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    program_loader #(
        .MEM_BYTES     (MEM),
        .START_BYTE    (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .write_enable (write_enable),
        .write_data   (write_data),
        .write_address(write_address),
        .clear_mem    (clear_mem),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .state_o      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // Accepted frame bytes are collected in m_q; position in the frame is
    // simply the queue length, so outcomes follow directly from the frame format.
    logic [7:0] m_q[$];
    int         m_mode = 0;   // 0: waiting for start, 1: clear cycle, 2: in frame
    int         m_idle = 0;
    int         m_len  = 0;
    int         m_n;
    logic [7:0] m_sum;
    logic       m_acc;
    logic       exp_ready = 1'b1, exp_we = 1'b0, exp_clr = 1'b0;
    logic       exp_hold = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
    logic [7:0] exp_wd = 8'h00;
    int         exp_wa = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_idle = 0; m_len = 0; m_q.delete();
            exp_ready = 1'b1; exp_we = 1'b0; exp_clr = 1'b0;
            exp_hold = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
            exp_wd = 8'h00; exp_wa = 0;
        end else begin
            m_acc   = rx_valid && exp_ready;
            exp_we  = 1'b0;
            exp_clr = 1'b0;
            if (m_mode == 0) begin
                if (m_acc && rx_data == 8'hA5) begin
                    m_mode = 1; exp_clr = 1'b1; exp_ready = 1'b0;
                    exp_hold = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
                end
            end else if (m_mode == 1) begin
                m_mode = 2; exp_ready = 1'b1; m_idle = 0; m_q.delete();
            end else if (m_acc) begin
                m_idle = 0;
                m_q.push_back(rx_data);
                m_n = m_q.size();
                if (m_n == 2) begin
                    m_len = {m_q[1], m_q[0]};
                    if (m_len > MEM) begin
                        m_mode = 0; exp_err = 1'b1;
                    end
                end
                if (m_n >= 3 && m_n <= 2 + m_len) begin
                    exp_we = 1'b1; exp_wa = m_n - 3; exp_wd = m_q[m_n-1];
                end
                if (m_mode == 2 && m_n == 3 + m_len) begin
                    m_sum = 8'h00;
                    for (int i = 2; i < m_n - 1; i++) m_sum = m_sum + m_q[i];
                    m_mode = 0;
                    if (m_sum == m_q[m_n-1]) begin
                        exp_done = 1'b1; exp_hold = 1'b0;
                    end else begin
                        exp_err = 1'b1;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_mode = 0; exp_err = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        check("rx_ready", 40'(rx_ready), 40'(exp_ready));
        check("write_enable", 40'(write_enable), 40'(exp_we));
        check("clear_mem", 40'(clear_mem), 40'(exp_clr));
        check("cpu_hold", 40'(cpu_hold), 40'(exp_hold));
        check("load_done", 40'(load_done), 40'(exp_done));
        check("load_error", 40'(load_error), 40'(exp_err));
        if (exp_we) begin
            check("write_data", 40'(write_data), 40'(exp_wd));
            check("write_address", 40'(write_address), 40'(exp_wa));
        end
    end

    // ---------------- scoreboard of literal writes ----------------
    logic [39:0] exp_q[$];
    int          clr_cnt = 0;
    int          cyc = 0;
    int          clr_cyc = 0;
    logic        first_wr_pending = 1'b0;
    logic [39:0] exp_w;

    always @(negedge clk) begin
        cyc++;
        if (clear_mem) begin
            clr_cnt++;
            clr_cyc = cyc;
            first_wr_pending = 1'b1;
        end
        if (write_enable) begin
            if (first_wr_pending) begin
                check("clear_to_write_gap_ge3", 40'(cyc - clr_cyc >= 3), 40'd1);
                first_wr_pending = 1'b0;
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         write_address, write_data);
            end else begin
                exp_w = exp_q.pop_front();
                check("write_list", {write_address, write_data}, exp_w);
            end
        end
    end

    // ---------------- driver ----------------
    logic [7:0] seq[$];

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte: byte %0h not accepted, rx_ready %0b expected 1", b, rx_ready);
            rx_valid = 1'b0;
        end else begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_seq(input int gap);
        foreach (seq[i]) send_byte(seq[i], (i == 0) ? 0 : gap);
    endtask

    task automatic expect_status(input string tag, input logic d, input logic e, input logic h);
        check({tag, "_done"}, 40'(load_done), 40'(d));
        check({tag, "_error"}, 40'(load_error), 40'(e));
        check({tag, "_hold"}, 40'(cpu_hold), 40'(h));
    endtask

    task automatic expect_writes_drained(input string tag);
        check({tag, "_writes_left"}, 40'(exp_q.size()), 40'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_ready", 40'(rx_ready), 40'd1);
        check("reset_write_enable", 40'(write_enable), 40'd0);
        check("reset_write_data", 40'(write_data), 40'd0);
        check("reset_write_address", 40'(write_address), 40'd0);
        check("reset_clear_mem", 40'(clear_mem), 40'd0);
        expect_status("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal four-byte frame, back to back.
        clr_cnt = 0;
        exp_q = '{{32'd0, 8'h13}, {32'd1, 8'h00}, {32'd2, 8'h00}, {32'd3, 8'h00}};
        seq = '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_seq(0);
        expect_status("nominal", 1'b1, 1'b0, 1'b0);
        check("nominal_clear_pulses", 40'(clr_cnt), 40'd1);
        expect_writes_drained("nominal");

        // Bad checksum: 1+2=3, sent 4.
        exp_q = '{{32'd0, 8'h01}, {32'd1, 8'h02}};
        seq = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h04};
        send_seq(0);
        expect_status("badsum", 1'b0, 1'b1, 1'b1);
        expect_writes_drained("badsum");

        // Recovery frame whose payload and checksum equal the start marker.
        exp_q = '{{32'd0, 8'hA5}};
        seq = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5};
        send_seq(0);
        expect_status("marker_in_frame", 1'b1, 1'b0, 1'b0);
        expect_writes_drained("marker_in_frame");

        // Oversize length 1025.
        seq = '{8'hA5, 8'h01, 8'h04};
        send_seq(0);
        expect_status("oversize", 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        expect_writes_drained("oversize");

        // Zero-length frame with 5 idle cycles between bytes.
        seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(5);
        expect_status("zero_gap5", 1'b1, 1'b0, 1'b0);

        // Gap of TMO-1 idle cycles after LEN_LO: byte lands on the last allowed cycle.
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, TMO - 1);
        send_byte(8'h00, 0);
        expect_status("zero_gap_tmo_minus1", 1'b1, 1'b0, 1'b0);

        // Gap of TMO idle cycles after LEN_LO times out.
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, TMO);
        send_byte(8'h00, 0);
        expect_status("timeout", 1'b0, 1'b1, 1'b1);

        // Noise before the marker, then reset in the middle of the payload.
        clr_cnt = 0;
        exp_q = '{{32'd0, 8'hA5}, {32'd1, 8'h11}};
        seq = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h00, 8'hA5, 8'h11};
        send_seq(0);
        check("noise_clear_pulses", 40'(clr_cnt), 40'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_rx_ready", 40'(rx_ready), 40'd1);
        check("midrst_write_enable", 40'(write_enable), 40'd0);
        check("midrst_write_data", 40'(write_data), 40'd0);
        check("midrst_write_address", 40'(write_address), 40'd0);
        check("midrst_clear_mem", 40'(clear_mem), 40'd0);
        expect_status("midrst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        expect_writes_drained("midrst");
        @(negedge clk);

        // Clean frame after reset: 7E, checksum 7E.
        exp_q = '{{32'd0, 8'h7E}};
        seq = '{8'hA5, 8'h01, 8'h00, 8'h7E, 8'h7E};
        send_seq(0);
        expect_status("after_reset", 1'b1, 1'b0, 1'b0);
        expect_writes_drained("after_reset");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached before end of stimulus");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
